count_arb: RTL
==============

COUNT_ARB -- requirements
Module: count_arb

Interface
REQ-001 SHALL have parameter WIDTH, default 4, counter and terminal-value width in bits.
REQ-002 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port req  input  2  per-requester request for a count run; bit i = requester i.
REQ-005 SHALL have port term0  input  WIDTH  terminal count for requester 0.
REQ-006 SHALL have port term1  input  WIDTH  terminal count for requester 1.
REQ-007 SHALL have port gnt  output  2  one-hot grant; at most one bit set.
REQ-008 SHALL have port done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 SHALL have port busy  output  1  high whenever state is not IDLE.
REQ-010 SHALL have port count  output  WIDTH  shared counter value.
REQ-011 SHALL have port pause  input  1  counter stall; present only under COUNT_PAUSE_EN.

Function
REQ-012 SHALL implement FSM with states IDLE, RUN, DONE; all outputs registered.
REQ-013 IDLE SHALL hold count=0, gnt=0, done=0, busy=0.
REQ-014 IDLE with req!=0 at an edge SHALL move to RUN on that edge: set gnt bit of winner, count=0, latch winner's term into term_q.
REQ-015 Arbitration SHALL be round-robin: single requester wins; with req=2'b11 the requester not served last wins; after reset, requester 0 wins the tie.
REQ-016 RUN with count!=term_q SHALL increment count by 1 per edge.
REQ-017 RUN with count==term_q SHALL move to DONE on that edge: done bit of granted requester=1, count held, gnt held.
REQ-018 DONE SHALL move to IDLE on the next edge: done=0, gnt=0, count=0, last-served pointer = granted index.
REQ-019 done SHALL be high exactly one cycle per run; the grant edge to done-high edge SHALL be term_q+1 edges.
REQ-020 term_q=0 SHALL give one RUN cycle with count=0, then DONE.
REQ-021 term_q=2^WIDTH-1 SHALL count to all-ones without wrap or overflow.
REQ-022 Runs SHALL be non-preemptive: req changes and term0/term1 changes during RUN/DONE SHALL be ignored.
REQ-023 A requester holding req through DONE SHALL be re-arbitrated in IDLE; minimum gap between runs is one IDLE cycle.

Reset
REQ-024 rst low SHALL immediately force state=IDLE, count=0, gnt=0, done=0, busy=0, term_q=0, pointer favoring requester 0, regardless of clk.
REQ-025 Reset mid-RUN or mid-DONE SHALL abort the run with no done pulse emitted.
REQ-026 After rst rises, the first edge SHALL be evaluated as IDLE.

Configuration
REQ-027 Macro COUNT_PAUSE_EN defined: pause port present; pause=1 in RUN holds count and blocks the RUN->DONE transition; pause has no effect in IDLE or DONE.
REQ-028 Macro COUNT_PAUSE_EN undefined: pause port absent; RUN never stalls; all other behaviour identical.

Verification
REQ-029 Reset, req=2'b01, term0=3 -> gnt=01 next edge; count 0,1,2,3; done=01 for one cycle; grant edge to done is 4 edges; then gnt=00, count=0.
REQ-030 req=2'b11 held from reset, term0=2, term1=5 -> requester 0 served first, requester 1 second, then requester 0 again; one IDLE cycle between runs.
REQ-031 term1=0 and term0=15 in separate runs -> done after 1 and 16 edges respectively; count reaches 15 with no wrap.
REQ-032 rst low while count=2 of a term0=7 run -> outputs zero immediately; no done pulse; after release, req=01 restarts from count=0.
REQ-033 term0 changed 3->9 and req dropped during RUN -> run still ends at count=3 with one done pulse.
REQ-034 With COUNT_PAUSE_EN, pause=1 for 3 cycles at count=1 of a term0=4 run -> count holds at 1; done arrives 3 cycles later than REQ-019.

Source files
------------

// File: rtl/count_arb_if.sv
// count_arb_if -- request/grant/count bundle for count_arb.
// The pause signal exists only when COUNT_PAUSE_EN is defined.
interface count_arb_if #(
  parameter int unsigned WIDTH = 4
);
  logic [1:0]       req;
  logic [WIDTH-1:0] term0;
  logic [WIDTH-1:0] term1;
  logic [1:0]       gnt;
  logic [1:0]       done;
  logic             busy;
  logic [WIDTH-1:0] count;
`ifdef COUNT_PAUSE_EN
  logic             pause;
`endif

  modport master (
    output req, term0, term1,
    input  gnt, done, busy, count
`ifdef COUNT_PAUSE_EN
    , output pause
`endif
  );

  modport slave (
    input  req, term0, term1,
    output gnt, done, busy, count
`ifdef COUNT_PAUSE_EN
    , input pause
`endif
  );
endinterface

// File: rtl/count_arb.sv
// count_arb -- two-requester round-robin arbiter that runs a shared counter
// from 0 up to the winner's terminal value, then pulses done for one cycle.
// Optional feature macro: COUNT_PAUSE_EN (adds bus.pause to stall RUN).
module count_arb #(
  parameter int unsigned WIDTH = 4
) (
  input logic        clk,
  input logic        rst,
  count_arb_if.slave bus
);
  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] term_q, term_d;
  logic [1:0]       gnt_q, gnt_d;
  logic [1:0]       done_q, done_d;
  logic             busy_q, busy_d;
  logic             last_q, last_d;   // index of the requester served last
  logic             win;
  logic             stall;

  // Pick the winner: a lone requester wins, a tie goes to the one not served last.
  always_comb begin
    win = 1'b0;
    if (bus.req == 2'b01)      win = 1'b0;
    else if (bus.req == 2'b10) win = 1'b1;
    else                       win = ~last_q;
  end

  // Counter stall source; tied off when the pause feature is not built.
  always_comb begin
`ifdef COUNT_PAUSE_EN
    stall = bus.pause;
`else
    stall = 1'b0;
`endif
  end

  // Next-state logic for the IDLE/RUN/DONE run sequence.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    term_d  = term_q;
    gnt_d   = gnt_q;
    done_d  = done_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        count_d = '0;
        gnt_d   = '0;
        done_d  = '0;
        if (bus.req != 2'b00) begin
          state_d = S_RUN;
          gnt_d   = win ? 2'b10 : 2'b01;
          term_d  = win ? bus.term1 : bus.term0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (count_q == term_q) begin
            state_d = S_DONE;
            done_d  = gnt_q;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        done_d  = '0;
        gnt_d   = '0;
        count_d = '0;
        last_d  = gnt_q[1];
      end
      default: begin
        state_d = S_IDLE;
        count_d = '0;
        gnt_d   = '0;
        done_d  = '0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  // State registers; reset favours requester 0 on the first tie.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      term_q  <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      busy_q  <= 1'b0;
      last_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      term_q  <= term_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      last_q  <= last_d;
    end
  end

  assign bus.gnt   = gnt_q;
  assign bus.done  = done_q;
  assign bus.busy  = busy_q;
  assign bus.count = count_q;
endmodule
